// File: rtl/bar_pkg.sv
// Shared LED bar definitions: phase pattern table, encoder helper and popcount.
// Used by both the bar decoder and bar_encoder so the table lives in one place.
package bar_pkg;

    localparam int BAR_W      = 6;
    localparam int NUM_PHASES = 10;

    typedef logic [3:0] bar_phase_t;

    typedef struct packed {
        bar_phase_t phase;
        logic       blank;
        logic       illegal;
    } bar_enc_t;

    // Index i holds the lit pattern (active-high) for phase i.
    localparam logic [NUM_PHASES-1:0][BAR_W-1:0] PHASE_PAT = {
        6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111111,
        6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001
    };

    function automatic bar_enc_t pattern_to_phase(input logic [BAR_W-1:0] pat);
        bar_enc_t r;
        r.phase   = '0;
        r.blank   = (pat == '0);
        r.illegal = (pat != '0);
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (pat == PHASE_PAT[i]) begin
                r.phase   = bar_phase_t'(i);
                r.illegal = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] bar_popcount(input logic [BAR_W-1:0] pat);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < BAR_W; i++) n = n + 3'(pat[i]);
        return n;
    endfunction

endpackage

// File: rtl/bar_debounce.sv
// Pad synchronizer plus stability counter; flags the bar pattern as debounced
// once it has held for DEBOUNCE_CYCLES consecutive cycles.
module bar_debounce
    import bar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BAR_W-1:0] pads_n,
    output logic             deb_valid,
    output logic [BAR_W-1:0] deb_pat
);

    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES);

    logic [BAR_W-1:0] sync1_q, sync2_q, prev_q, prev_d;
    logic [19:0]      stable_cnt_q, stable_cnt_d;
    logic [BAR_W-1:0] pat_s;

    assign pat_s = ~sync2_q;

    always_comb begin
        prev_d       = pat_s;
        stable_cnt_d = stable_cnt_q;
        if (pat_s != prev_q)             stable_cnt_d = '0;
        else if (stable_cnt_q != CNT_MAX) stable_cnt_d = stable_cnt_q + 20'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            prev_q       <= '0;
            stable_cnt_q <= '0;
        end else begin
            sync1_q      <= pads_n;
            sync2_q      <= sync1_q;
            prev_q       <= prev_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    // A saturated count alone is stale on the first cycle of a new value.
    assign deb_valid = (stable_cnt_q == CNT_MAX) && (pat_s == prev_q);
    assign deb_pat   = prev_q;

endmodule

// File: rtl/bar_encoder.sv
// Debounced LED bar pattern -> phase index, presented on a valid/ready output.
// Optional BAR_ENCODER_ERRCNT_EN adds a saturating illegal-pattern counter.
module bar_encoder
    import bar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BAR_W-1:0] pads_n,
`ifdef BAR_ENCODER_ERRCNT_EN
    output logic [7:0]       err_count,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_phase,
    output logic             out_blank,
    output logic             out_illegal,
    output logic [2:0]       level
);

    typedef enum logic {TRACK, PRESENT} state_t;

    state_t           state_q, state_d;
    logic             deb_valid, accept;
    logic [BAR_W-1:0] deb_pat;
    logic [BAR_W-1:0] last_acc_q, last_acc_d;
    bar_enc_t         enc_q, enc_d;
    logic [2:0]       level_q, level_d;

    bar_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk       (clk),
        .rst       (rst),
        .pads_n    (pads_n),
        .deb_valid (deb_valid),
        .deb_pat   (deb_pat)
    );

    assign accept = deb_valid && (deb_pat != last_acc_q) && (state_q == TRACK);

    always_ff @(posedge clk) begin
        if (rst) state_q <= TRACK;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACK:   if (accept)    state_d = PRESENT;
            PRESENT: if (out_ready) state_d = TRACK;
            default:                state_d = TRACK;
        endcase
    end

    always_comb begin
        out_valid = (state_q == PRESENT);
    end

    always_comb begin
        last_acc_d = last_acc_q;
        enc_d      = enc_q;
        level_d    = level_q;
        if (deb_valid) level_d = bar_popcount(deb_pat);
        if (accept) begin
            last_acc_d = deb_pat;
            enc_d      = pattern_to_phase(deb_pat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_acc_q    <= '0;
            enc_q.phase   <= '0;
            enc_q.blank   <= 1'b1;
            enc_q.illegal <= 1'b0;
            level_q       <= '0;
        end else begin
            last_acc_q <= last_acc_d;
            enc_q      <= enc_d;
            level_q    <= level_d;
        end
    end

    assign out_phase   = enc_q.phase;
    assign out_blank   = enc_q.blank;
    assign out_illegal = enc_q.illegal;
    assign level       = level_q;

`ifdef BAR_ENCODER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && enc_d.illegal && err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_bar_encoder.sv
// Scoreboard bench for bar_encoder with DEBOUNCE_CYCLES=4: directed pad
// patterns push expected results; a negedge monitor checks each transfer.
module tb_bar_encoder;

    localparam int DEB = 4;

    typedef struct {
        logic [3:0] phase;
        logic       blank;
        logic       illegal;
        logic [2:0] level;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] pads_n = 6'h3f;
    logic       out_valid, out_ready = 1'b1;
    logic [3:0] out_phase;
    logic       out_blank, out_illegal;
    logic [2:0] level;
`ifdef BAR_ENCODER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    bar_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .pads_n      (pads_n),
`ifdef BAR_ENCODER_ERRCNT_EN
        .err_count   (err_count),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_phase   (out_phase),
        .out_blank   (out_blank),
        .out_illegal (out_illegal),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] ph, input logic bl, input logic il, input logic [2:0] lv);
        exp_t e;
        e.phase = ph; e.blank = bl; e.illegal = il; e.level = lv;
        sb_q.push_back(e);
    endtask

    task automatic set_pat(input logic [5:0] pat);
        @(negedge clk);
        pads_n = ~pat;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout, %0d results still expected", name, sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: phase %0d blank %0d illegal %0d with nothing expected",
                         out_phase, out_blank, out_illegal);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_phase",   int'(out_phase),   int'(e.phase));
                check("sb_blank",   int'(out_blank),   int'(e.blank));
                check("sb_illegal", int'(out_illegal), int'(e.illegal));
                check("sb_level",   int'(level),       int'(e.level));
            end
        end
    end

    initial begin
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   int'(out_valid),   0);
        check("rst_phase",   int'(out_phase),   0);
        check("rst_blank",   int'(out_blank),   1);
        check("rst_illegal", int'(out_illegal), 0);
        check("rst_level",   int'(level),       0);
`ifdef BAR_ENCODER_ERRCNT_EN
        check("rst_errcnt",  int'(err_count),   0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Glitch shorter than the debounce window is ignored entirely
        set_pat(6'b000111);
        repeat (3) @(negedge clk);
        pads_n = 6'h3f;
        repeat (20) @(negedge clk);
        check("glitch_level", int'(level), 0);
        check("glitch_valid", int'(out_valid), 0);

        // Clean step to phase 1: valid rises DEB+3 edges after the sampling edge
        push(4'd1, 1'b0, 1'b0, 3'd2);
        set_pat(6'b000011);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        check("latency_edges", n - 1, DEB + 3);
        drain("phase1");

        push(4'd0, 1'b1, 1'b0, 3'd0);
        set_pat(6'b000000);
        drain("blank");

        push(4'd0, 1'b0, 1'b1, 3'd3);
        set_pat(6'b010101);
        drain("illegal");

        push(4'd0, 1'b1, 1'b0, 3'd0);
        set_pat(6'b000000);
        drain("blank2");

        // Re-entering last accepted pattern yields nothing
        set_pat(6'b000000);
        repeat (20) @(negedge clk);
        check("same_no_valid", int'(out_valid), 0);

        // Backpressure: phase 0 held, phase 7 dropped, phase 8 follows
        out_ready = 1'b0;
        set_pat(6'b000001);
        repeat (DEB + 10) @(negedge clk);
        set_pat(6'b111000);
        repeat (DEB + 10) @(negedge clk);
        set_pat(6'b110000);
        repeat (DEB + 10) @(negedge clk);
        check("bp_valid_held", int'(out_valid), 1);
        check("bp_phase_held", int'(out_phase), 0);
        check("bp_level",      int'(level),     2);
        push(4'd0, 1'b0, 1'b0, 3'd2);
        push(4'd8, 1'b0, 1'b0, 3'd2);
        out_ready = 1'b1;
        drain("backpressure");

        // Reset while presenting discards the result; re-accepted afterwards
        out_ready = 1'b0;
        set_pat(6'b111111);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_phase", int'(out_phase), 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drops_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        push(4'd5, 1'b0, 1'b0, 3'd6);
        out_ready = 1'b1;
        drain("rst_represent");

`ifdef BAR_ENCODER_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            push(4'd0, 1'b0, 1'b1, 3'd3);
            set_pat(6'b010101);
            drain("err_illegal");
            if (i == 0) check("errcnt_first", int'(err_count), 1);
            push(4'd0, 1'b1, 1'b0, 3'd0);
            set_pat(6'b000000);
            drain("err_blank");
        end
        check("errcnt_sat", int'(err_count), 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bar_encoder.md
# bar_encoder

Input-side companion to the LED bar decoder. It samples a 6-bit active-low pad bus, for example DIP switches or a looped-back LED bar. It synchronizes and debounces the bus, then encodes each newly stable bar pattern back into its 0–9 phase index. Each result is delivered on a valid/ready output with a registered lit-LED level. It sits between the board pads and any consumer that needs the bar position as a number (self-check logic, a status register).

## Interface
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable cycles required before a pattern is accepted (10 ms at 27 MHz); legal range 1 to 2^20−1.
- `clk` input 1: sole clock.
- `rst` input 1: reset, synchronous, active-high; one clock domain only.
- `pads_n` input 6: asynchronous active-low bar pads; internal pattern `pat = ~pads_n`.
- `out_valid` output 1: an encoded result is presented.
- `out_ready` input 1: consumer accepts; transfer occurs on a cycle with `out_valid && out_ready`.
- `out_phase` output 4: phase 0–9; 0 when blank or illegal.
- `out_blank` output 1: accepted pattern is 000000.
- `out_illegal` output 1: accepted pattern is not in the phase table and is not blank.
- `level` output 3: popcount of the current debounced pattern (0–6).

## Operation
- Phase table (`pat` → phase):
  - Filling: 000001→0, 000011→1, 000111→2, 001111→3, 011111→4, 111111→5.
  - Draining: 111100→6, 111000→7, 110000→8, 100000→9.
- Sync: 2-flop synchronizer on `pads_n`; the flops reset to 6'b111111.
- Debounce:
  - `stable_cnt` clears whenever the synchronized pattern differs from its previous-cycle value; otherwise it increments.
  - It saturates at `DEBOUNCE_CYCLES`.
  - The pattern is "debounced" while `stable_cnt == DEBOUNCE_CYCLES`.
- `level` is updated from the debounced pattern only; it holds while the bus is bouncing.
- Acceptance requires the pattern to be debounced, to differ from `last_acc`, and the FSM to be in TRACK. On acceptance:
  - `last_acc` is loaded with the pattern.
  - The output fields are encoded and registered.
- FSM states:
  - TRACK: `out_valid` = 0. On acceptance, go to PRESENT.
  - PRESENT: `out_valid` = 1 and all out_* fields are held stable. On `out_ready`, return to TRACK.
- While in PRESENT, debouncing continues but nothing is accepted. Intermediate patterns are dropped, and only the newest stable pattern is accepted after the transfer. Because the counter is saturated, that acceptance happens on the first TRACK cycle.
- Re-entering a pattern equal to `last_acc` produces no output.
- Returning to 000000 after a non-blank pattern produces an output with `out_blank` = 1.

## Timing
- Reset values:
  - `out_valid` 0, `out_phase` 0, `out_blank` 1, `out_illegal` 0, `level` 0.
  - State TRACK, `stable_cnt` 0, `last_acc` 000000.
- Latency: with `out_ready` high and a clean pad step, `out_valid` rises exactly `DEBOUNCE_CYCLES` + 3 rising edges after the edge that first samples the new `pads_n` value.
- Handshake:
  - Transfer on a cycle with `out_valid && out_ready`.
  - `out_valid` falls on the following edge.
  - Minimum gap between two transfers is 1 cycle, spent in TRACK.
  - `out_ready` is ignored in TRACK.
- A bounce of one cycle or more restarts the count in full; there is no partial credit.
- `rst` asserted mid-PRESENT: the pending result is discarded and `out_valid` drops on that edge. If the pads hold a non-blank pattern, it is re-accepted after a full debounce.

## Configuration
- `BAR_ENCODER_ERRCNT_EN` defined:
  - Adds output `err_count` [7:0].
  - Increments on each accepted illegal pattern, at acceptance (not at transfer).
  - Saturates at 255; cleared by `rst`.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package `bar_pkg`:
  - `BAR_W` = 6, `NUM_PHASES` = 10, `typedef logic [3:0] bar_phase_t`.
  - Constant pattern table.
  - Function `pattern_to_phase`, returning phase, blank and illegal.
- The decoder side uses the same table.
- Sub-module `bar_debounce`: synchronizer, `stable_cnt`, and debounced pattern/strobe.
- Top `bar_encoder`: acceptance, encoding, FSM, level, and the optional error counter.

## Test plan
- `DEBOUNCE_CYCLES`=4, `out_ready`=1, `pads_n` 111111→111100 (pat 000011) → `out_valid` pulses 7 edges later with `out_phase`=1, `level`=2.
- Glitch: `pat`=000111 for 3 cycles, then back to 000000 → no `out_valid`; `level` stays 0.
- Backpressure: `out_ready`=0, `pat` 000001, then 111000, then 110000 → holds `out_phase`=0. After `out_ready`=1, the next result is `out_phase`=8 and phase 7 is never output.
- Illegal: `pat`=010101 → `out_illegal`=1, `out_phase`=0. With `BAR_ENCODER_ERRCNT_EN`, 300 alternating illegal/blank acceptances → `err_count`=255.
- `rst` pulsed while `out_valid`=1 with `pat`=111111 → `out_valid` 0 on that edge, then re-presents `out_phase`=5 after `DEBOUNCE_CYCLES`+3 edges.
